// File: rtl/wb_link_if.sv
// ---------------------------------------------------------------------------
// wb_link_if
//   Signal bundle between the EX/MEM side, the ID-stage hazard query and the
//   wb_link_stage MEM/WB boundary register.
//
//   Parameters: DATA_W (data/PC width), REG_AW (register address width).
//
//   Signals (direction as seen by the stage, i.e. the slave modport):
//     in_valid  in   EX/MEM slot holds a real instruction
//     jal       in   2'b10 jal, 2'b11 jalr (build-dependent), else plain write
//     pc        in   address of the branch instruction
//     alu_data  in   ALU/memory result
//     rd_in     in   decoded destination register
//     we_in     in   instruction writes a register
//     stall     in   hold the stage
//     flush     in   replace the incoming slot with a bubble
//     rs_q/rt_q in   ID-stage source registers
//     wb_valid  out  WB slot holds a real instruction
//     wb_we     out  register file write enable
//     wb_addr   out  register file write address
//     wb_data   out  register file write data
//     hazard    out  ID must stall (combinational)
// ---------------------------------------------------------------------------
interface wb_link_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              in_valid;
  logic [1:0]        jal;
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] alu_data;
  logic [REG_AW-1:0] rd_in;
  logic              we_in;
  logic              stall;
  logic              flush;
  logic [REG_AW-1:0] rs_q;
  logic [REG_AW-1:0] rt_q;
  logic              wb_valid;
  logic              wb_we;
  logic [REG_AW-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              hazard;

  // Upstream pipeline / ID side.
  modport master (
    output in_valid, jal, pc, alu_data, rd_in, we_in, stall, flush, rs_q, rt_q,
    input  wb_valid, wb_we, wb_addr, wb_data, hazard
  );

  // The MEM/WB stage itself.
  modport slave (
    input  in_valid, jal, pc, alu_data, rd_in, we_in, stall, flush, rs_q, rt_q,
    output wb_valid, wb_we, wb_addr, wb_data, hazard
  );
endinterface

// File: rtl/wb_link_stage.sv
// ---------------------------------------------------------------------------
// wb_link_stage
//   Registered MEM/WB boundary for a pipeline without forwarding paths.
//   Picks the writeback destination/value (substituting the link register and
//   pc+LINK_OFFSET for jal), registers it for the register file, and keeps a
//   DEPTH-entry window of in-flight destinations from which a combinational
//   hazard stall for ID is derived.
//
//   Optional feature macro: WB_LINK_JALR_EN
//     defined   : jal=2'b11 (jalr) writes pc+LINK_OFFSET to rd_in, we=1
//     undefined : jal=2'b11 behaves as a plain write
//
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-high reset (deassertion synchronised upstream)
//     bus  wb_link_if.slave (pipeline inputs, ID sources, WB outputs, hazard)
// ---------------------------------------------------------------------------
module wb_link_stage #(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int LINK_REG    = 31,
  parameter int LINK_OFFSET = 8,
  parameter int DEPTH       = 2
) (
  input  logic     clk,
  input  logic     rst,
  wb_link_if.slave bus
);

  localparam logic [REG_AW-1:0] LINK_ADDR = REG_AW'(LINK_REG);
  localparam logic [DATA_W-1:0] LINK_OFS  = DATA_W'(LINK_OFFSET);

  // Effective destination of the incoming slot.
  logic [DATA_W-1:0] link_data;
  logic [REG_AW-1:0] eff_addr;
  logic [DATA_W-1:0] eff_data;
  logic              eff_we;

  // Values actually presented to the stage register (bubble when !in_valid).
  logic [REG_AW-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              load_we;

  // Window entry 0 doubles as the WB write port register.
  logic              win_we_reg   [DEPTH];
  logic [REG_AW-1:0] win_addr_reg [DEPTH];
  logic              wb_valid_reg;
  logic [DATA_W-1:0] wb_data_reg;

  logic [REG_AW-1:0] rs_q;
  logic [REG_AW-1:0] rt_q;
  logic [DEPTH-1:0]  win_hit;
  logic              incoming_hit;

  // Wraps modulo 2^DATA_W by construction.
  assign link_data = bus.pc + LINK_OFS;

  always_comb begin
    eff_addr = bus.rd_in;
    eff_data = bus.alu_data;
    eff_we   = bus.we_in;
    if (bus.jal == 2'b10) begin
      eff_addr = LINK_ADDR;
      eff_data = link_data;
      eff_we   = 1'b1;
    end
`ifdef WB_LINK_JALR_EN
    else if (bus.jal == 2'b11) begin
      eff_data = link_data;
      eff_we   = 1'b1;
    end
`endif
    // r0 is hardwired: never written, so it can never be a pending destination.
    if (eff_addr == '0) begin
      eff_we = 1'b0;
    end
  end

  always_comb begin
    load_we   = 1'b0;
    load_addr = '0;
    load_data = '0;
    if (bus.in_valid) begin
      load_we   = eff_we;
      load_addr = eff_addr;
      load_data = eff_data;
    end
  end

  // Stage register. The data/valid part and the destination window share the
  // same advance condition: flush always advances (pushing a bubble), a plain
  // stall freezes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_reg <= 1'b0;
      wb_data_reg  <= '0;
    end else if (bus.flush) begin
      wb_valid_reg <= 1'b0;
      wb_data_reg  <= '0;
    end else if (!bus.stall) begin
      wb_valid_reg <= bus.in_valid;
      wb_data_reg  <= load_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        win_we_reg[k]   <= 1'b0;
        win_addr_reg[k] <= '0;
      end
    end else if (bus.flush || !bus.stall) begin
      win_we_reg[0]   <= bus.flush ? 1'b0 : load_we;
      win_addr_reg[0] <= bus.flush ? '0 : load_addr;
      for (int k = 1; k < DEPTH; k++) begin
        win_we_reg[k]   <= win_we_reg[k-1];
        win_addr_reg[k] <= win_addr_reg[k-1];
      end
    end
  end

  assign bus.wb_valid = wb_valid_reg;
  assign bus.wb_we    = win_we_reg[0];
  assign bus.wb_addr  = win_addr_reg[0];
  assign bus.wb_data  = wb_data_reg;

  // Hazard detection: a nonzero source matching any pending write.
  assign rs_q = bus.rs_q;
  assign rt_q = bus.rt_q;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
    assign win_hit[gi] = win_we_reg[gi] &&
                         (((rs_q != '0) && (rs_q == win_addr_reg[gi])) ||
                          ((rt_q != '0) && (rt_q == win_addr_reg[gi])));
  end

  // The instruction about to enter WB is also unreadable this cycle.
  assign incoming_hit = bus.in_valid && eff_we &&
                        (((rs_q != '0) && (rs_q == eff_addr)) ||
                         ((rt_q != '0) && (rt_q == eff_addr)));

  assign bus.hazard = (|win_hit) || incoming_hit;

endmodule

// File: tb/tb_wb_link_stage.sv
module tb_wb_link_stage;

  localparam int DATA_W      = 32;
  localparam int REG_AW      = 5;
  localparam int LINK_REG    = 31;
  localparam int LINK_OFFSET = 8;
  localparam int DEPTH       = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wb_link_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();

  wb_link_stage #(
    .DATA_W(DATA_W), .REG_AW(REG_AW), .LINK_REG(LINK_REG),
    .LINK_OFFSET(LINK_OFFSET), .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        in_valid;
    logic [1:0]  jal;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        we;
    logic        exp_valid;
    logic        exp_we;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  typedef struct {
    logic       we;
    logic [4:0] addr;
  } dest_t;

  vec_t  vecs [8];
  dest_t hist [$];   // most recent load first, at most DEPTH entries

  // Reference model state for the WB register.
  logic        m_valid;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid = 1'b0; bus.jal = 2'b00; bus.pc = '0; bus.alu_data = '0;
    bus.rd_in = '0; bus.we_in = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
    bus.rs_q = '0; bus.rt_q = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    hist.delete();
    m_valid = 0; m_we = 0; m_addr = 0; m_data = 0;
  endtask

  // Spec rules for the effective destination, written straight from the table.
  task automatic model_eff(input logic [1:0] jal, input logic [31:0] pc, input logic [31:0] alu,
                           input logic [4:0] rd, input logic we,
                           output logic [4:0] ea, output logic [31:0] ed, output logic ew);
    bit link_op;
    link_op = (jal == 2'b10);
`ifdef WB_LINK_JALR_EN
    link_op = link_op || (jal == 2'b11);
`endif
    ea = (jal == 2'b10) ? 5'(LINK_REG) : rd;
    ed = link_op ? (pc + 32'(LINK_OFFSET)) : alu;
    ew = link_op ? 1'b1 : we;
    if (ea == 0) ew = 1'b0;
  endtask

  function automatic logic hits(input logic [4:0] a, input logic [4:0] rs, input logic [4:0] rt);
    return (a != 0) && (a == rs || a == rt);
  endfunction

  initial begin
    logic [4:0]  ea;
    logic [31:0] ed;
    logic        ew;
    logic        exp_hz;

    idle_inputs();

    // ---------------- vector table ----------------
    vecs[0] = '{1, 2'b10, 32'h0040_0010, 32'h1111_1111, 5'd9, 0, 1, 1, 5'd31, 32'h0040_0018};
    vecs[1] = '{1, 2'b10, 32'hFFFF_FFFC, 32'h2222_2222, 5'd9, 0, 1, 1, 5'd31, 32'h0000_0004};
    vecs[2] = '{1, 2'b00, 32'h0000_0100, 32'hDEAD_BEEF, 5'd5, 1, 1, 1, 5'd5,  32'hDEAD_BEEF};
    vecs[3] = '{1, 2'b00, 32'h0000_0100, 32'hCAFE_0000, 5'd0, 1, 1, 0, 5'd0,  32'hCAFE_0000};
    vecs[4] = '{0, 2'b10, 32'h0000_0200, 32'h3333_3333, 5'd7, 1, 0, 0, 5'd0,  32'h0000_0000};
    vecs[6] = '{1, 2'b01, 32'h0000_0300, 32'h4444_4444, 5'd6, 0, 1, 0, 5'd6,  32'h4444_4444};
`ifdef WB_LINK_JALR_EN
    vecs[5] = '{1, 2'b11, 32'h0000_0100, 32'h0000_0055, 5'd4, 0, 1, 1, 5'd4,  32'h0000_0108};
    vecs[7] = '{1, 2'b11, 32'h0000_0100, 32'h0000_0066, 5'd0, 1, 1, 0, 5'd0,  32'h0000_0108};
`else
    vecs[5] = '{1, 2'b11, 32'h0000_0100, 32'h0000_0055, 5'd4, 0, 1, 0, 5'd4,  32'h0000_0055};
    vecs[7] = '{1, 2'b11, 32'h0000_0100, 32'h0000_0066, 5'd0, 1, 1, 0, 5'd0,  32'h0000_0066};
`endif

    // ---------------- reset ----------------
    tick();
    rst = 1'b0;
    bus.in_valid = 1; bus.rd_in = 5'd12; bus.we_in = 1; bus.alu_data = 32'h1234_5678;
    tick();
    chk("preload_valid", 64'(bus.wb_valid), 64'd1);
    #2 rst = 1'b1;   // mid-cycle, asynchronous
    #1;
    chk("rst_valid", 64'(bus.wb_valid), 64'd0);
    chk("rst_we",    64'(bus.wb_we),    64'd0);
    chk("rst_addr",  64'(bus.wb_addr),  64'd0);
    chk("rst_data",  64'(bus.wb_data),  64'd0);
    idle_inputs();
    tick();
    rst = 1'b0;
    bus.rs_q = 5'd5;
    #1 chk("rst_hazard_r5", 64'(bus.hazard), 64'd0);
    $display("reset sequence done");

    // ---------------- table vectors ----------------
    for (int i = 0; i < 8; i++) begin
      idle_inputs();
      bus.in_valid = vecs[i].in_valid; bus.jal = vecs[i].jal; bus.pc = vecs[i].pc;
      bus.alu_data = vecs[i].alu; bus.rd_in = vecs[i].rd; bus.we_in = vecs[i].we;
      tick();
      chk($sformatf("vec%0d_valid", i), 64'(bus.wb_valid), 64'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_we", i),    64'(bus.wb_we),    64'(vecs[i].exp_we));
      chk($sformatf("vec%0d_addr", i),  64'(bus.wb_addr),  64'(vecs[i].exp_addr));
      chk($sformatf("vec%0d_data", i),  64'(bus.wb_data),  64'(vecs[i].exp_data));
      $display("vec %0d jal=%b pc=%h -> wb v=%b we=%b a=%0d d=%h", i, vecs[i].jal, vecs[i].pc,
               bus.wb_valid, bus.wb_we, bus.wb_addr, bus.wb_data);
    end

    // ---------------- hazard window ----------------
    idle_inputs();
    do_reset();
    bus.in_valid = 1; bus.rd_in = 5'd7; bus.we_in = 1; bus.alu_data = 32'h77;
    bus.rs_q = 5'd7; bus.rt_q = 5'd0;
    #1 chk("hz_incoming", 64'(bus.hazard), 64'd1);
    tick();
    bus.in_valid = 0; bus.we_in = 0; bus.rd_in = 0;
    #1 chk("hz_entry0", 64'(bus.hazard), 64'd1);
    bus.rs_q = 5'd0;
    #1 chk("hz_r0_never", 64'(bus.hazard), 64'd0);
    bus.rs_q = 5'd7;
    tick();
    #1 chk("hz_entry1", 64'(bus.hazard), 64'd1);
    tick();
    #1 chk("hz_aged_out", 64'(bus.hazard), 64'd0);
    $display("hazard window sequence done");

    // ---------------- stall / flush ----------------
    idle_inputs();
    bus.in_valid = 1; bus.rd_in = 5'd3; bus.we_in = 1; bus.alu_data = 32'h33;
    tick();
    bus.in_valid = 1; bus.rd_in = 5'd9; bus.we_in = 1; bus.alu_data = 32'h99;
    bus.stall = 1; bus.rs_q = 5'd3;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("st%0d_valid", c), 64'(bus.wb_valid), 64'd1);
      chk($sformatf("st%0d_addr", c),  64'(bus.wb_addr),  64'd3);
      chk($sformatf("st%0d_data", c),  64'(bus.wb_data),  64'h33);
      #1 chk($sformatf("st%0d_hazard", c), 64'(bus.hazard), 64'd1);
    end
    bus.flush = 1;
    tick();
    chk("fl_valid", 64'(bus.wb_valid), 64'd0);
    chk("fl_we",    64'(bus.wb_we),    64'd0);
    chk("fl_data",  64'(bus.wb_data),  64'd0);
    bus.in_valid = 0; bus.stall = 0; bus.flush = 0;
    #1 chk("fl_entry1_hazard", 64'(bus.hazard), 64'd1);
    tick();
    #1 chk("fl_aged_hazard", 64'(bus.hazard), 64'd0);
    $display("stall/flush sequence done");

    // ---------------- randomized vs. model ----------------
    idle_inputs();
    do_reset();
    for (int t = 0; t < 300; t++) begin
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.jal      = 2'($urandom_range(0, 3));
      bus.pc       = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7)) : $urandom;
      bus.alu_data = $urandom;
      bus.rd_in    = 5'($urandom_range(0, 7));
      bus.we_in    = 1'($urandom_range(0, 1));
      bus.stall    = ($urandom_range(0, 4) == 0);
      bus.flush    = ($urandom_range(0, 6) == 0);
      bus.rs_q     = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      bus.rt_q     = 5'($urandom_range(0, 7));
      model_eff(bus.jal, bus.pc, bus.alu_data, bus.rd_in, bus.we_in, ea, ed, ew);
      exp_hz = bus.in_valid && ew && hits(ea, bus.rs_q, bus.rt_q);
      foreach (hist[j]) if (hist[j].we && hits(hist[j].addr, bus.rs_q, bus.rt_q)) exp_hz = 1'b1;
      #1 chk("rnd_hazard", 64'(bus.hazard), 64'(exp_hz));
      tick();
      if (bus.flush || !bus.stall) begin
        dest_t d;
        if (bus.flush || !bus.in_valid) begin
          m_valid = 0; m_we = 0; m_addr = 0; m_data = 0;
        end else begin
          m_valid = 1; m_we = ew; m_addr = ea; m_data = ed;
        end
        d.we = m_we; d.addr = m_addr;
        hist.push_front(d);
        if (hist.size() > DEPTH) void'(hist.pop_back());
      end
      chk("rnd_valid", 64'(bus.wb_valid), 64'(m_valid));
      chk("rnd_we",    64'(bus.wb_we),    64'(m_we));
      chk("rnd_addr",  64'(bus.wb_addr),  64'(m_addr));
      chk("rnd_data",  64'(bus.wb_data),  64'(m_data));
      $display("rnd %0d st=%b fl=%b v=%b jal=%b -> wb v=%b we=%b a=%0d d=%h hz=%b", t,
               bus.stall, bus.flush, bus.in_valid, bus.jal, bus.wb_valid, bus.wb_we,
               bus.wb_addr, bus.wb_data, exp_hz);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
